// File: rtl/pc_stack_param.sv
// Parametrised LIFO return-address stack with occupancy and sticky overflow/underflow status.
// Optional PC_STACK_WRAP_EN: push while full overwrites the oldest entry instead of being dropped.
module pc_stack_param #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic              err_clr,
    input  logic [ADDR_W-1:0] stack_in,
    output logic [ADDR_W-1:0] stack_out,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_up;
    logic [PTR_W-1:0]  ptr_dn;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wr_en;
    logic              set_ov;
    logic              set_un;

    // Explicit wrap so non-power-of-2 depths stay inside the storage array.
    assign ptr_up = (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    assign ptr_dn = (ptr == '0) ? LAST : ptr - PTR_W'(1);

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign stack_out = empty ? '0 : mem[ptr];

    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = count;
        wr_en   = 1'b0;
        wr_ptr  = ptr;
        set_ov  = 1'b0;
        set_un  = 1'b0;
        if (clear) begin
            ptr_nxt = '0;
            cnt_nxt = '0;
        end else if (push && pop) begin
            if (empty) begin
                wr_en   = 1'b1;
                wr_ptr  = ptr_up;
                ptr_nxt = ptr_up;
                cnt_nxt = CNT_W'(1);
                set_un  = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_ptr = ptr;
            end
        end else if (push) begin
            if (!full) begin
                wr_en   = 1'b1;
                wr_ptr  = ptr_up;
                ptr_nxt = ptr_up;
                cnt_nxt = count + CNT_W'(1);
            end else begin
                set_ov = 1'b1;
`ifdef PC_STACK_WRAP_EN
                // The slot after the top is the oldest entry when full.
                wr_en   = 1'b1;
                wr_ptr  = ptr_up;
                ptr_nxt = ptr_up;
`else
                wr_en   = 1'b0;
`endif
            end
        end else if (pop) begin
            if (empty) begin
                set_un = 1'b1;
            end else begin
                ptr_nxt = ptr_dn;
                cnt_nxt = count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            count <= cnt_nxt;
            if (wr_en) mem[wr_ptr] <= stack_in;
            overflow  <= set_ov | (overflow  & ~err_clr);
            underflow <= set_un | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_pc_stack_param.sv
// Scoreboarded bench for pc_stack_param: queue-based LIFO model, directed scenarios then random traffic.
module tb_pc_stack_param;

    localparam int AW = 11;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0, pop = 1'b0, clear = 1'b0, err_clr = 1'b0;
    logic [AW-1:0] stack_in = '0;
    logic [AW-1:0] stack_out;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    pc_stack_param #(.ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear),
        .err_clr(err_clr), .stack_in(stack_in), .stack_out(stack_out),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] out;
        int            cnt;
        logic          emp;
        logic          ful;
        logic          ov;
        logic          un;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] model[$];
    logic          m_ov = 1'b0, m_un = 1'b0;
    int            total = 0;
    int            bad = 0;

    function automatic exp_t model_state();
        exp_t e;
        e.out = (model.size() > 0) ? model[$] : '0;
        e.cnt = model.size();
        e.emp = (model.size() == 0);
        e.ful = (model.size() == D);
        e.ov  = m_ov;
        e.un  = m_un;
        return e;
    endfunction

    task automatic compare(input string name, input exp_t e);
        total++;
        if (stack_out !== e.out || int'(count) != e.cnt || empty !== e.emp ||
            full !== e.ful || overflow !== e.ov || underflow !== e.un) begin
            bad++;
            $display("FAIL %s: got out=%h cnt=%0d e=%b f=%b ov=%b un=%b, want out=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                     name, stack_out, count, empty, full, overflow, underflow,
                     e.out, e.cnt, e.emp, e.ful, e.ov, e.un);
        end
    endtask

    // Reference behaviour: a plain queue whose back is the top of the stack.
    task automatic model_step(input logic pu, input logic po, input logic cl,
                              input logic ec, input logic [AW-1:0] d);
        logic sov = 1'b0, sun = 1'b0;
        if (cl) begin
            model.delete();
        end else if (pu && po) begin
            if (model.size() == 0) begin
                model.push_back(d);
                sun = 1'b1;
            end else begin
                model[model.size()-1] = d;
            end
        end else if (pu) begin
            if (model.size() < D) begin
                model.push_back(d);
            end else begin
                sov = 1'b1;
`ifdef PC_STACK_WRAP_EN
                void'(model.pop_front());
                model.push_back(d);
`endif
            end
        end else if (po) begin
            if (model.size() == 0) sun = 1'b1;
            else void'(model.pop_back());
        end
        if (ec) begin
            m_ov = 1'b0;
            m_un = 1'b0;
        end
        if (sov) m_ov = 1'b1;
        if (sun) m_un = 1'b1;
    endtask

    task automatic step(input logic pu, input logic po, input logic cl,
                        input logic ec, input logic [AW-1:0] d);
        @(negedge clk);
        push = pu; pop = po; clear = cl; err_clr = ec; stack_in = d;
        if (rst) begin
            model.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            model_step(pu, po, cl, ec, d);
        end
        exp_q.push_back(model_state());
    endtask

    // Monitor: every expectation belongs to the edge following its issue.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare("edge", exp_q.pop_front());
    end

    initial begin
        exp_t rst_e;
        rst_e = model_state();
        #2;
        compare("reset_state", rst_e);
        @(negedge clk);
        rst = 1'b0;

        // Basic push/pop ordering
        step(1, 0, 0, 0, 11'h005);
        step(1, 0, 0, 0, 11'h123);
        step(1, 0, 0, 0, 11'h7FF);
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);

        // Fill past capacity, then drain beyond empty
        for (int i = 1; i <= 9; i++) step(1, 0, 0, 0, AW'(i));
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, '0);

        // Underflow on empty, then clear flags
        step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, '0);

        // Replace top with simultaneous push and pop
        step(1, 0, 0, 0, 11'h033);
        step(1, 0, 0, 0, 11'h0AA);
        step(1, 1, 0, 0, 11'h055);
        step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, 11'h0F0);
        step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, 11'h1F1);

        // Flag set beats err_clr on the same edge
        step(0, 0, 1, 1, '0);
        step(0, 1, 0, 1, '0);

        // Clear with count=5 leaves flags alone
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, AW'(11'h100 + i));
        step(1, 1, 1, 0, 11'h3AB);
        step(0, 1, 0, 0, '0);

        // Asynchronous reset between edges
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, AW'(11'h200 + i));
        @(posedge clk);
        #3;
        rst = 1'b1;
        model.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        #1;
        compare("async_reset", model_state());
        step(1, 0, 0, 0, 11'h222);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            logic pu, po, cl, ec;
            r  = $urandom_range(0, 99);
            pu = (r < 45);
            po = (r >= 35 && r < 80);
            cl = (r >= 97);
            ec = ($urandom_range(0, 19) == 0);
            step(pu, po, cl, ec, AW'($urandom));
        end
        step(0, 0, 0, 0, '0);

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
